// File: rtl/regfile_xfer_seq_if.sv
// Bundled control, register-file and stream signals of the load/store-multiple sequencer.
// The master modport is the sequencer side; slave is the surrounding environment.
interface regfile_xfer_seq_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        input  start, mode, base, count, rf_rdata, out_ready, in_data, in_valid,
        output busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata, out_data, out_valid, in_ready
    );

    modport slave (
        output start, mode, base, count, rf_rdata, out_ready, in_data, in_valid,
        input  busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/regfile_xfer_seq.sv
// Load/store-multiple sequencer: SAVE streams COUNT registers from BASE out on a valid/ready port,
// RESTORE writes COUNT words from a valid/ready input stream back into the register file.
module regfile_xfer_seq #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_xfer_seq_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_HOLD,
        WR_ACC,
        FIN
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1) << ADDR_W;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   rem_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] rf_raddr_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              in_ready_q;

    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W:0]   count_d;
    logic              last_d;

    // ptr wraps naturally at 2**ADDR_W; requested counts beyond the file size clamp to a full sweep
    always_comb begin
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
        last_d  = (rem_q == (ADDR_W+1)'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_raddr_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rf_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy stays up through the done cycle, which is spent here
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        ptr_q  <= bus.base;
                        rem_q  <= count_d;
                        if (count_d == '0) begin
                            state_q <= FIN;
                        end else if (!bus.mode) begin
                            rf_raddr_q <= bus.base;
                            state_q    <= RD_ADDR;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= WR_ACC;
                        end
                    end
                end
                RD_ADDR: begin
                    out_data_q  <= bus.rf_rdata;
                    out_valid_q <= 1'b1;
                    state_q     <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        rem_q       <= rem_q - (ADDR_W+1)'(1);
                        if (last_d) begin
                            state_q <= FIN;
                        end else begin
                            ptr_q      <= ptr_d;
                            rf_raddr_q <= ptr_d;
                            state_q    <= RD_ADDR;
                        end
                    end
                end
                WR_ACC: begin
                    if (bus.in_valid && in_ready_q) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= ptr_q;
                        rf_wdata_q <= bus.in_data;
                        ptr_q      <= ptr_d;
                        rem_q      <= rem_q - (ADDR_W+1)'(1);
                        if (last_d) begin
                            in_ready_q <= 1'b0;
                            state_q    <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_raddr  = rf_raddr_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule
